// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps one request outstanding to instruction memory and
// registers the returned word into a single-entry output slot that decode drains.
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic [31:0]     instr_q;
  logic            hs;
  logic            consume;

  assign hs          = imem_req && imem_ready;
  assign consume     = if_valid && !id_stall;
  assign imem_addr   = pc;
  assign if_instr    = if_valid ? instr_q : NOP_INSTR;
  assign if_opcode   = if_instr[6:0];
  assign if_pc_plus4 = if_pc + XLEN'(4);

  // A redirect never changes the state sequence; it only retargets pc and marks
  // an in-flight request for dropping via kill.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req = !if_valid || !id_stall;
        if (imem_req && imem_ready) state_next = WAIT;
      end
      WAIT: if (imem_rvalid) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      kill         <= 1'b0;
      if_valid     <= 1'b0;
      if_pc        <= RESET_PC;
      instr_q      <= NOP_INSTR;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (consume) if_valid <= 1'b0;
      if (redirect_valid) begin
        pc           <= {redirect_pc[XLEN-1:2], 2'b00};
        misalign_err <= |redirect_pc[1:0];
        if_valid     <= 1'b0;
        if (state == REQ && hs) kill <= 1'b1;
        else if (state == WAIT) kill <= !imem_rvalid;  // same-cycle response is dropped outright
      end else if (state == WAIT && imem_rvalid) begin
        if (kill) begin
          kill <= 1'b0;
        end else begin
          instr_q  <= imem_rdata;
          if_pc    <= pc;
          if_valid <= 1'b1;
          pc       <= pc + XLEN'(4);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a memory/decode driver pushes the instructions that
// must reach decode into a scoreboard queue; a negedge monitor pops and compares them.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, id_stall;
  logic [31:0] redirect_pc;
  logic        if_valid, misalign_err;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic [6:0]  if_opcode;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .misalign_err(misalign_err)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int consumes = 0;
  bit drv_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0100;
      1: return 32'h0000_0202;
      2: return 32'hFFFF_FFFC;
      3: return 32'hFFFF_FFF4;
      4: return 32'h0000_0008;
      default: return $urandom;
    endcase
  endfunction

  // Driver: memory with 1..3 cycle response latency, random stalls/redirects, two mid-run
  // resets while a request is outstanding (its response arrives just after reset).
  initial begin
    bit          busy, live, hs_s, rd_s;
    int          lat, rst_cnt, next_rst;
    logic [31:0] baddr, addr_s;
    busy = 0; live = 0; lat = 0; rst_cnt = 0; next_rst = 1000; baddr = '0;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      hs_s = imem_req && imem_ready; addr_s = imem_addr; rd_s = redirect_valid;
      @(posedge clk); #1;
      if (hs_s) begin
        busy = 1; baddr = addr_s; live = !rd_s && rst_n; lat = $urandom_range(0, 2);
      end
      redirect_valid = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
      if (cyc < 3 || rst_cnt > 0) begin
        rst_n = 1'b0; live = 0;
        if (rst_cnt > 0) rst_cnt--;
      end else if (!rst_n) begin
        rst_n = 1'b1;
        if (busy) begin imem_rvalid = 1'b1; busy = 0; end  // late response, must be ignored
      end else if (cyc >= next_rst && busy && lat > 0) begin
        rst_n = 1'b0; rst_cnt = 1; live = 0; next_rst += 1000;
      end else begin
        imem_ready = $urandom_range(0, 9) < 7;
        id_stall   = $urandom_range(0, 9) < 3;
        if ($urandom_range(0, 11) == 0) begin
          redirect_valid = 1'b1; redirect_pc = pick_target();
        end
        if (busy) begin
          if (lat == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem(baddr); busy = 0;
            if (live && !redirect_valid) q.push_back('{pc: baddr, instr: mem(baddr)});
          end else begin
            lat--;
            if (redirect_valid) live = 0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          imem_rvalid = 1'b1;  // stray response outside WAIT
        end
      end
    end
    drv_done = 1;
  end

  // Monitor: architectural model of the fetch stream plus scoreboard comparison.
  initial begin
    bit          prev_rst, prev_rd, prev_mis;
    logic [31:0] fetch_exp;
    int          idle;
    exp_t        e;
    prev_rst = 0; prev_rd = 0; prev_mis = 0; fetch_exp = '0; idle = 0;
    while (!drv_done) begin
      @(negedge clk);
      if (!prev_rst) begin
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        fetch_exp = 32'h0; q.delete(); idle = 0;
      end else begin
        check("misalign_err", 32'(misalign_err), 32'(prev_rd && prev_mis));
        if (!if_valid) check("nop_when_empty", if_instr, NOP);
        if (if_valid && id_stall) begin
          check("req_blocked_by_stall", 32'(imem_req), 32'd0);
          if (q.size() > 0) check("held_pc", if_pc, q[0].pc);
        end
        if (if_valid && !id_stall) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_instr actual pc=%h instr=%h expected none", if_pc, if_instr);
          end else begin
            e = q.pop_front();
            check("if_pc", if_pc, e.pc);
            check("if_instr", if_instr, e.instr);
            check("if_opcode", 32'(if_opcode), 32'(e.instr[6:0]));
            check("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
          end
          consumes++; idle = 0;
        end else if (redirect_valid && q.size() > 0) begin
          void'(q.pop_front());  // slot flushed by redirect
        end
        if (imem_req && imem_ready) begin
          check("fetch_addr", imem_addr, fetch_exp);
          fetch_exp += 32'd4;
        end
        if (redirect_valid) fetch_exp = {redirect_pc[31:2], 2'b00};
        idle++;
        if (idle > 200) begin
          checks++; failures++; idle = 0;
          $display("FAIL progress actual=no consume in 200 cycles required=consume");
        end
      end
      prev_rst = rst_n; prev_rd = redirect_valid; prev_mis = |redirect_pc[1:0];
    end
    check("consume_count_ok", 32'(consumes > 100), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
